// File: rtl/uart_hdx_arbiter.sv
// Half-duplex line-ownership arbiter for the UART: grants the shared line to RX or TX,
// inserts bit-time guard intervals at each turnaround and caps TX bursts.
module uart_hdx_arbiter #(
  parameter int unsigned GUARD_BITS  = 2,
  parameter int unsigned TX_BURST    = 4,
  parameter int unsigned LISTEN_BITS = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       fullduplex_i,
  input  logic       rx_i,
  input  logic       rx_frame_active_i,
  input  logic       tx_pending_i,
  input  logic       tx_busy_i,
  output logic       rx_enable_o,
  output logic       tx_enable_o,
  output logic       line_dir_o,
  output logic       collision_o,
  output logic [2:0] state_o
);

  localparam int unsigned GW = (GUARD_BITS > 0) ? $clog2(GUARD_BITS + 1) : 1;
  localparam int unsigned LW = (LISTEN_BITS > 0) ? $clog2(LISTEN_BITS + 1) : 1;
  localparam int unsigned BW = (TX_BURST > 1) ? $clog2(TX_BURST) : 1;

  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_BITS - 1);
  localparam logic [LW-1:0] LISTEN_MAX = LW'(LISTEN_BITS);
  localparam logic [BW-1:0] BURST_LAST = BW'(TX_BURST - 1);

  typedef enum logic [2:0] {
    ST_LISTEN    = 3'd0,
    ST_RX_BUSY   = 3'd1,
    ST_TURN_TX   = 3'd2,
    ST_TX_ACTIVE = 3'd3,
    ST_TURN_RX   = 3'd4,
    ST_FD        = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          busy_q;
  logic          rx_en_d, dir_d, coll_d;
  logic          done, end_burst;

  // A frame completes on the falling edge of tx_busy_i.
  assign done      = busy_q & ~tx_busy_i;
  assign end_burst = done & ((bcnt_q == BURST_LAST) | ~tx_pending_i);

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    gcnt_d  = gcnt_q;
    bcnt_d  = bcnt_q;
    coll_d  = 1'b0;

    unique case (state_q)
      ST_LISTEN: begin
        if (!rx_i || rx_frame_active_i) begin
          state_d = ST_RX_BUSY;
        end else begin
          if (tick_i && (lcnt_q != LISTEN_MAX)) lcnt_d = lcnt_q + LW'(1);
          if (tx_pending_i && (lcnt_q == LISTEN_MAX)) begin
            state_d = ST_TURN_TX;
            gcnt_d  = '0;
          end
        end
      end
      ST_RX_BUSY: begin
        if (!rx_frame_active_i && rx_i) begin
          state_d = ST_LISTEN;
          lcnt_d  = '0;
        end
      end
      ST_TURN_TX: begin
        // Far end started talking while we were about to drive: back off.
        if (!rx_i) begin
          state_d = ST_RX_BUSY;
          coll_d  = 1'b1;
        end else if (tick_i) begin
          if (gcnt_q == GUARD_LAST) begin
            state_d = ST_TX_ACTIVE;
            bcnt_d  = '0;
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
      end
      ST_TX_ACTIVE: begin
        if (end_burst || (tick_i && !tx_busy_i && !tx_pending_i)) begin
          state_d = ST_TURN_RX;
          gcnt_d  = '0;
        end else if (done) begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      ST_TURN_RX: begin
        if (tick_i) begin
          if (gcnt_q == GUARD_LAST) begin
            state_d = ST_LISTEN;
            lcnt_d  = '0;
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
      end
      ST_FD: begin
        if (!fullduplex_i) begin
          state_d = ST_LISTEN;
          lcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_LISTEN;
        lcnt_d  = '0;
      end
    endcase

    // Full-duplex mode overrides every other transition, including a collision abort.
    if (fullduplex_i) begin
      state_d = ST_FD;
      coll_d  = 1'b0;
    end

    rx_en_d = (state_d == ST_LISTEN) || (state_d == ST_RX_BUSY) || (state_d == ST_FD);
    dir_d   = (state_d == ST_TX_ACTIVE) || (state_d == ST_FD);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LISTEN;
      lcnt_q      <= '0;
      gcnt_q      <= '0;
      bcnt_q      <= '0;
      busy_q      <= 1'b0;
      rx_enable_o <= 1'b1;
      line_dir_o  <= 1'b0;
      collision_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      gcnt_q      <= gcnt_d;
      bcnt_q      <= bcnt_d;
      busy_q      <= tx_busy_i;
      rx_enable_o <= rx_en_d;
      line_dir_o  <= dir_d;
      collision_o <= coll_d;
    end
  end

  // Enable drops in the done cycle itself so no new frame starts on the way out.
  assign tx_enable_o = ((state_q == ST_TX_ACTIVE) && !end_burst) || (state_q == ST_FD);
  assign state_o     = state_q;

endmodule

// File: tb/tb_uart_hdx_arbiter.sv
// Self-checking bench for uart_hdx_arbiter: per-cycle comparison against a behavioural
// model plus directed latency/collision/full-duplex/reset expectations.
module tb_uart_hdx_arbiter;

  localparam int GUARD  = 2;
  localparam int BURST  = 4;
  localparam int LISTEN = 11;
  localparam int FRAME  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick_i = 1'b1;
  logic       fullduplex_i = 1'b0;
  logic       rx_i = 1'b1;
  logic       rx_frame_active_i = 1'b0;
  logic       tx_pending_i = 1'b1;
  logic       tx_busy_i = 1'b0;
  logic       rx_enable_o, tx_enable_o, line_dir_o, collision_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_per = 1;
  int tcnt     = 0;
  int queue    = 6;
  int left     = 0;
  logic en_s   = 1'b0;
  int lat;

  uart_hdx_arbiter #(
    .GUARD_BITS (GUARD),
    .TX_BURST   (BURST),
    .LISTEN_BITS(LISTEN)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tick_i           (tick_i),
    .fullduplex_i     (fullduplex_i),
    .rx_i             (rx_i),
    .rx_frame_active_i(rx_frame_active_i),
    .tx_pending_i     (tx_pending_i),
    .tx_busy_i        (tx_busy_i),
    .rx_enable_o      (rx_enable_o),
    .tx_enable_o      (tx_enable_o),
    .line_dir_o       (line_dir_o),
    .collision_o      (collision_o),
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h @%0t", name, act, exp, $time);
  endtask

  // Baud tick generator.
  initial forever begin
    @(posedge clk); #1;
    tcnt++;
    tick_i = (tick_per <= 1) ? 1'b1 : ((tcnt % tick_per) == 0);
  end

  // Simple TX engine: pops a queued frame when enabled, stays busy FRAME cycles.
  initial forever begin
    @(negedge clk);
    en_s = tx_enable_o;
    @(posedge clk); #1;
    if (tx_busy_i) begin
      left--;
      if (left == 0) tx_busy_i = 1'b0;
    end else if (en_s && queue > 0) begin
      queue--;
      tx_busy_i = 1'b1;
      left = FRAME;
    end
    tx_pending_i = (queue > 0);
  end

  // Behavioural model: counts idle ticks, guard ticks and frames in the current grant.
  int m_state = 0, m_idle = 0, m_guard = 0, m_frames = 0, m_nxt = 0;
  bit m_bprev = 1'b0, m_rx_en = 1'b1, m_dir = 1'b0, m_coll = 1'b0, m_done = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_state = 0; m_idle = 0; m_guard = 0; m_frames = 0;
      m_bprev = 1'b0; m_rx_en = 1'b1; m_dir = 1'b0; m_coll = 1'b0;
    end else begin
      m_done = m_bprev && !tx_busy_i;
      m_coll = 1'b0;
      m_nxt  = m_state;
      if (fullduplex_i) m_nxt = 5;
      else case (m_state)
        0: if (!rx_i || rx_frame_active_i) m_nxt = 1;
           else if (tx_pending_i && m_idle >= LISTEN) m_nxt = 2;
           else if (tick_i) m_idle++;
        1: if (rx_i && !rx_frame_active_i) m_nxt = 0;
        2: if (!rx_i) begin m_nxt = 1; m_coll = 1'b1; end
           else if (tick_i) begin m_guard++; if (m_guard == GUARD) m_nxt = 3; end
        3: begin
             if (m_done) m_frames++;
             if (m_done && (m_frames == BURST || !tx_pending_i)) m_nxt = 4;
             else if (tick_i && !tx_busy_i && !tx_pending_i) m_nxt = 4;
           end
        4: if (tick_i) begin m_guard++; if (m_guard == GUARD) m_nxt = 0; end
        default: m_nxt = 0;
      endcase
      if (m_nxt != m_state) begin m_idle = 0; m_guard = 0; m_frames = 0; end
      m_state = m_nxt;
      m_bprev = tx_busy_i;
      m_rx_en = (m_state == 0) || (m_state == 1) || (m_state == 5);
      m_dir   = (m_state == 3) || (m_state == 5);
    end
  end

  function automatic bit exp_tx_en();
    bit d;
    if (m_state == 5) return 1'b1;
    if (m_state != 3) return 1'b0;
    d = m_bprev && !tx_busy_i;
    return !(d && ((m_frames + 1 == BURST) || !tx_pending_i));
  endfunction

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    check("rx_enable_o", rx_enable_o, m_rx_en);
    check("tx_enable_o", tx_enable_o, exp_tx_en());
    check("line_dir_o",  line_dir_o,  m_dir);
    check("collision_o", collision_o, m_coll);
    check("state_o",     state_o,     m_state);
  end

  task automatic wait_state(input int s, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (state_o == 3'(s)) begin cycles = i; break; end
    end
    check($sformatf("reach_state%0d", s), (cycles > 0), 1);
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (state_o == 3'd0 && !tx_busy_i && queue == 0 && !tx_pending_i) begin ok = 1'b1; break; end
    end
    check("idle_reached", ok, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_en"}, rx_enable_o, 1);
    check({tag, "_tx_en"}, tx_enable_o, 0);
    check({tag, "_dir"},   line_dir_o,  0);
    check({tag, "_coll"},  collision_o, 0);
    check({tag, "_state"}, state_o,     0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;

    // Idle line with pending TX: 11 ticks + 1 cycle + 2 guard ticks.
    wait_state(3, 100, lat);
    check("first_grant_latency", lat, 14);
    check("grant_tx_en", tx_enable_o, 1);
    check("grant_dir", line_dir_o, 1);

    // Burst capped at 4 of 6 frames, then TURN_RX + LISTEN + TURN_TX before the second grant.
    wait_state(4, 200, lat);
    check("burst1_frames", 6 - queue, 4);
    wait_state(3, 100, lat);
    check("second_grant_latency", lat, 16);
    wait_state(4, 200, lat);
    check("burst2_queue_empty", queue, 0);
    wait_state(0, 50, lat);

    // Start bit during TURN_TX.
    tick_per = 3;
    queue = 1;
    wait_state(2, 200, lat);
    rx_i = 1'b0;
    @(posedge clk); #1;
    check("coll_state", state_o, 1);
    check("coll_pulse", collision_o, 1);
    check("coll_dir", line_dir_o, 0);
    @(posedge clk); #1;
    check("coll_pulse_end", collision_o, 0);
    tick_per = 1;
    repeat (2) @(posedge clk);
    #1 rx_i = 1'b1;

    // Frame activity at lcnt=7 restarts the listen window.
    wait_state(0, 5, lat);
    repeat (7) begin @(posedge clk); #1; end
    rx_frame_active_i = 1'b1;
    wait_state(1, 5, lat);
    rx_frame_active_i = 1'b0;
    wait_state(0, 5, lat);
    wait_state(2, 50, lat);
    check("relisten_latency", lat, 12);
    wait_state(4, 100, lat);
    wait_state(0, 50, lat);

    // Full-duplex entry from TX_ACTIVE and exit back to LISTEN.
    queue = 3;
    wait_state(3, 100, lat);
    fullduplex_i = 1'b1;
    @(posedge clk); #1;
    check("fd_state", state_o, 5);
    check("fd_rx_en", rx_enable_o, 1);
    check("fd_tx_en", tx_enable_o, 1);
    check("fd_dir", line_dir_o, 1);
    repeat (10) @(posedge clk);
    #1 fullduplex_i = 1'b0;
    @(posedge clk); #1;
    check("fdx_state", state_o, 0);
    check("fdx_rx_en", rx_enable_o, 1);
    check("fdx_tx_en", tx_enable_o, 0);
    check("fdx_dir", line_dir_o, 0);
    wait_idle(600);

    // Asynchronous reset in the middle of TX_ACTIVE.
    queue = 4;
    wait_state(3, 100, lat);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_state(2, 50, lat);
    check("post_reset_latency", lat, 12);
    repeat (150) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_hdx_arbiter.md
# uart_hdx_arbiter

Line-ownership arbiter for the UART in half-duplex mode. It decides when the receiver may listen and when the transmitter may drive the single shared line, and it inserts bit-time guard intervals at every direction change. It caps each transmit burst so the far end always gets a listen window, and it grants both directions at once in full-duplex mode. It sits between the UART configuration register, the TX engine and the RX engine, and its `rx_enable_o` drives the receiver's `rx_enable_i`.

## Interface
Parameters:
- GUARD_BITS, 2: bit-times (ticks) the line is left undriven at each turnaround; must be ≥1.
- TX_BURST, 4: maximum TX frames per grant; must be ≥1.
- LISTEN_BITS, 11: idle bit-times the line must be observed before TX may be granted.

Ports:
- clk  in  1  system clock. This is the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_i  in  1  one-cycle baud-period strobe. All bit-time counters advance only on cycles where it is high.
- fullduplex_i  in  1  mode select, taken from `uart_config.mode == FULLDUPLEX`.
- rx_i  in  1  synchronized line level. Idle is 1.
- rx_frame_active_i  in  1  receiver is mid-frame (not idle).
- tx_pending_i  in  1  TX FIFO is not empty.
- tx_busy_i  in  1  transmitter is shifting a frame.
- rx_enable_o  out  1  receiver may accept start bits.
- tx_enable_o  out  1  transmitter may start a frame.
- line_dir_o  out  1  1 = local driver on the line, 0 = released.
- collision_o  out  1  one-cycle pulse when a turnaround to TX is aborted by incoming traffic.
- state_o  out  3  current state encoding, for debug and CSR.

## Operation
- State encoding: LISTEN=0, RX_BUSY=1, TURN_TX=2, TX_ACTIVE=3, TURN_RX=4, FD=5.
- Internal registers:
  - gcnt: guard counter.
  - lcnt: listen counter, saturates at LISTEN_BITS.
  - bcnt: burst counter, 0..TX_BURST-1.
  - busy_q: previous `tx_busy_i`.
- done = busy_q & ~tx_busy_i.
- Global rule: `fullduplex_i`=1 forces FD from any state.
- FD:
  - rx_en=1, tx_en=1, dir=1.
  - When `fullduplex_i` falls, go to LISTEN with lcnt=0.
- LISTEN:
  - rx_en=1, tx_en=0, dir=0.
  - lcnt increments on each tick while `rx_i`=1.
  - If `rx_i`=0 or `rx_frame_active_i`=1, go to RX_BUSY. This check has priority.
  - Else if `tx_pending_i`=1 and lcnt==LISTEN_BITS, go to TURN_TX with gcnt=0.
- RX_BUSY:
  - rx_en=1, tx_en=0, dir=0.
  - When `rx_frame_active_i`=0 and `rx_i`=1, go to LISTEN with lcnt=0.
- TURN_TX:
  - rx_en=0, tx_en=0, dir=0.
  - gcnt increments on each tick. A tick with gcnt==GUARD_BITS-1 moves to TX_ACTIVE with bcnt=0.
  - If `rx_i`=0 in any cycle of this state: go to RX_BUSY and pulse collision_o. This check has priority over guard expiry.
- TX_ACTIVE:
  - rx_en=0, dir=1.
  - On done with bcnt==TX_BURST-1, or on done with `tx_pending_i`=0: go to TURN_RX with gcnt=0.
  - On done otherwise: bcnt increments.
  - On a tick with `tx_busy_i`=0 and `tx_pending_i`=0: go to TURN_RX.
  - tx_enable_o = (state==TX_ACTIVE) & ~end_burst, where end_burst = done & (bcnt==TX_BURST-1 | ~tx_pending_i). This term is combinational so that no new frame starts on the exit cycle.
- TURN_RX:
  - rx_en=0, tx_en=0, dir=0.
  - A tick with gcnt==GUARD_BITS-1 moves to LISTEN with lcnt=0.
- Reset mid-operation: all state returns to LISTEN immediately and asynchronously. An in-flight TX frame loses its enable; the transmitter is responsible for its own reset.

## Timing
- Reset values:
  - state=LISTEN, lcnt=0, gcnt=0, bcnt=0, busy_q=0.
  - rx_enable_o=1, tx_enable_o=0, line_dir_o=0, collision_o=0, state_o=0.
- rx_enable_o, line_dir_o, state_o and collision_o are registered. They change on the same clk edge as the state transition, one cycle after the triggering input.
- tx_enable_o is registered-state AND combinational end_burst, so it drops in the done cycle itself.
- Turnaround lasts exactly GUARD_BITS ticks, counted from the first tick after state entry.
- Minimum TX grant latency from line idle equals LISTEN_BITS ticks, plus 1 cycle, plus GUARD_BITS ticks.
- If the FD entry condition and another transition occur in the same cycle, FD wins.
- Counter widths are $clog2(max+1). lcnt saturates and never wraps. bcnt wraps only via state exit.

## Test plan
- Reset with `fullduplex_i`=0 and the line idle, `tx_pending_i`=1 → rx_en=1 for 11 ticks, TURN_TX for 2 ticks with all outputs 0, then TX_ACTIVE with tx_en=1 and dir=1.
- TX burst with 6 frames queued and TX_BURST=4 → exactly 4 done pulses, tx_en low on the 4th done cycle, TURN_RX for 2 ticks, LISTEN for 11 ticks, then the second grant.
- Start bit (`rx_i`=0) arrives during TURN_TX → RX_BUSY on the next cycle, collision_o high for 1 cycle, dir stays 0.
- `rx_frame_active_i` pulses while lcnt=7 in LISTEN → RX_BUSY. After release lcnt restarts at 0, and TX waits a full 11 idle ticks.
- `fullduplex_i` rises during TX_ACTIVE → next cycle state=5 and all enables=1. When it falls → LISTEN, rx_en=1, tx_en=0.
- `rst_n` asserted mid-TX_ACTIVE → outputs take their reset values with no clock edge. After release the block is in LISTEN with lcnt=0.
